// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared mode, selector and carry constants for the 74181-style ALU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic LOGICFUNC = 1'b1;
  localparam logic ARITHOP   = 1'b0;

  localparam logic CARRY_ON  = 1'b1;
  localparam logic CARRY_OFF = 1'b0;

  // Logic-mode selector codes (Mode = LOGICFUNC)
  localparam logic [3:0] LOGIC_NOT_A     = 4'h0;
  localparam logic [3:0] LOGIC_NOR       = 4'h1;
  localparam logic [3:0] LOGIC_NOTA_AND_B = 4'h2;
  localparam logic [3:0] LOGIC_ZERO      = 4'h3;
  localparam logic [3:0] LOGIC_NAND      = 4'h4;
  localparam logic [3:0] LOGIC_NOT_B     = 4'h5;
  localparam logic [3:0] LOGIC_XOR       = 4'h6;
  localparam logic [3:0] LOGIC_A_ANDN_B  = 4'h7;
  localparam logic [3:0] LOGIC_NOTA_OR_B = 4'h8;
  localparam logic [3:0] LOGIC_XNOR      = 4'h9;
  localparam logic [3:0] LOGIC_B         = 4'hA;
  localparam logic [3:0] LOGIC_AND       = 4'hB;
  localparam logic [3:0] LOGIC_ONES      = 4'hC;
  localparam logic [3:0] LOGIC_A_ORN_B   = 4'hD;
  localparam logic [3:0] LOGIC_OR        = 4'hE;
  localparam logic [3:0] LOGIC_A         = 4'hF;

  // Arithmetic-mode selector codes (Mode = ARITHOP), value before carry-in
  localparam logic [3:0] ARITH_A          = 4'h0;
  localparam logic [3:0] ARITH_A_OR_B     = 4'h1;
  localparam logic [3:0] ARITH_A_ORN_B    = 4'h2;
  localparam logic [3:0] ARITH_ONES       = 4'h3;
  localparam logic [3:0] ARITH_A_PL_ANB   = 4'h4;
  localparam logic [3:0] ARITH_AOB_PL_ANB = 4'h5;
  localparam logic [3:0] ARITH_A_MI_B_MI1 = 4'h6;
  localparam logic [3:0] ARITH_ANB_MI1    = 4'h7;
  localparam logic [3:0] ARITH_A_PL_AB    = 4'h8;
  localparam logic [3:0] ARITH_A_PL_B     = 4'h9;
  localparam logic [3:0] ARITH_AONB_PL_AB = 4'hA;
  localparam logic [3:0] ARITH_AB_MI1     = 4'hB;
  localparam logic [3:0] ARITH_A_PL_A     = 4'hC;
  localparam logic [3:0] ARITH_AOB_PL_A   = 4'hD;
  localparam logic [3:0] ARITH_AONB_PL_A  = 4'hE;
  localparam logic [3:0] ARITH_A_MI1      = 4'hF;

  // Common aliases; INC and SUB rely on CARRY_ON
  localparam logic [3:0] ARITH_INC = ARITH_A;
  localparam logic [3:0] ARITH_ADD = ARITH_A_PL_B;
  localparam logic [3:0] ARITH_SUB = ARITH_A_MI_B_MI1;
  localparam logic [3:0] ARITH_DBL = ARITH_A_PL_A;
  localparam logic [3:0] ARITH_DEC = ARITH_A_MI1;

endpackage

`default_nettype wire

// File: rtl/alu_comb.sv
// ============================================================================
// Module : alu_comb
// Brief  : Combinational 74181-style function generator (X/Y terms, sum, logic).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             mode,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  logic [WIDTH-1:0] x_term;
  logic [WIDTH-1:0] y_term;
  logic [WIDTH:0]   sum;

  assign x_term = a | (b & {WIDTH{sel[0]}}) | (~b & {WIDTH{sel[1]}});
  assign y_term = (a & ~b & {WIDTH{sel[2]}}) | (a & b & {WIDTH{sel[3]}});

  assign sum = {1'b0, x_term} + {1'b0, y_term} + {{WIDTH{1'b0}}, carry_in};

  // Logic mode passes carry-in straight through
  always_comb begin
    result    = sum[WIDTH-1:0];
    carry_out = sum[WIDTH];
    if (mode == LOGICFUNC) begin
      result    = ~(x_term ^ y_term);
      carry_out = carry_in;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_core_8.sv
// ============================================================================
// Module : alu_core_8
// Brief  : Registered 8-bit ALU; ZeroFlag logic present only when
//          ALU_ZERO_FLAG_EN is defined, otherwise ZeroFlag is tied low.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_core_8
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Mode,
  input  logic [3:0]       Selector,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  output logic [WIDTH-1:0] F,
  output logic             CarryOut,
  output logic             ZeroFlag
);

  logic [WIDTH-1:0] next_f;
  logic             next_carry;

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .mode      (Mode),
    .sel       (Selector),
    .a         (A),
    .b         (B),
    .carry_in  (CarryIn),
    .result    (next_f),
    .carry_out (next_carry)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      F        <= '0;
      CarryOut <= CARRY_OFF;
    end else begin
      F        <= next_f;
      CarryOut <= next_carry;
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  // Flag tracks the value being registered, so it never lags F
  always_ff @(posedge CLK) begin
    if (RST) ZeroFlag <= 1'b1;
    else     ZeroFlag <= (next_f == '0);
  end
`else
  assign ZeroFlag = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_core_8.sv
// Directed table plus a random sweep of all 32 Mode/Selector codes for alu_core_8.
`default_nettype none

module tb_alu_core_8;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [3:0] sel;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] f;
  logic       co;
  logic       zf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_core_8 #(.WIDTH(8)) dut (
    .CLK      (clk),
    .RST      (rst),
    .Mode     (mode),
    .Selector (sel),
    .A        (a),
    .B        (b),
    .CarryIn  (cin),
    .F        (f),
    .CarryOut (co),
    .ZeroFlag (zf)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       mode;
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] f;
    logic       co;
  } vec_t;

  vec_t vecs[$];

  function automatic logic exp_zero(input logic [7:0] fv);
`ifdef ALU_ZERO_FLAG_EN
    return (fv == 8'h00);
`else
    return 1'b0;
`endif
  endfunction

  // Reference written from the function tables, arithmetic as a pair of addends
  task automatic model(input logic m, input logic [3:0] s, input logic [7:0] av,
                       input logic [7:0] bv, input logic c,
                       output logic [7:0] fv, output logic cv);
    logic [7:0] p, q;
    logic [8:0] sum;
    if (m) begin
      case (s)
        4'h0: fv = ~av;        4'h1: fv = ~(av | bv);
        4'h2: fv = ~av & bv;   4'h3: fv = 8'h00;
        4'h4: fv = ~(av & bv); 4'h5: fv = ~bv;
        4'h6: fv = av ^ bv;    4'h7: fv = av & ~bv;
        4'h8: fv = ~av | bv;   4'h9: fv = ~(av ^ bv);
        4'hA: fv = bv;         4'hB: fv = av & bv;
        4'hC: fv = 8'hFF;      4'hD: fv = av | ~bv;
        4'hE: fv = av | bv;    default: fv = av;
      endcase
      cv = c;
    end else begin
      case (s)
        4'h0: begin p = av;       q = 8'h00;     end
        4'h1: begin p = av | bv;  q = 8'h00;     end
        4'h2: begin p = av | ~bv; q = 8'h00;     end
        4'h3: begin p = 8'hFF;    q = 8'h00;     end
        4'h4: begin p = av;       q = av & ~bv;  end
        4'h5: begin p = av | bv;  q = av & ~bv;  end
        4'h6: begin p = av;       q = ~bv;       end
        4'h7: begin p = 8'hFF;    q = av & ~bv;  end
        4'h8: begin p = av;       q = av & bv;   end
        4'h9: begin p = av;       q = bv;        end
        4'hA: begin p = av | ~bv; q = av & bv;   end
        4'hB: begin p = 8'hFF;    q = av & bv;   end
        4'hC: begin p = av;       q = av;        end
        4'hD: begin p = av | bv;  q = av;        end
        4'hE: begin p = av | ~bv; q = av;        end
        default: begin p = 8'hFF; q = av;        end
      endcase
      sum = {1'b0, p} + {1'b0, q} + {8'h00, c};
      fv  = sum[7:0];
      cv  = sum[8];
    end
  endtask

  task automatic check_outs(input string nm, input logic [7:0] ef, input logic ec);
    logic ez;
    ez = exp_zero(ef);
    checks++;
    if (f !== ef) begin
      failures++;
      $display("FAIL %s F: got %02h expected %02h", nm, f, ef);
    end
    checks++;
    if (co !== ec) begin
      failures++;
      $display("FAIL %s CarryOut: got %0b expected %0b", nm, co, ec);
    end
    checks++;
    if (zf !== ez) begin
      failures++;
      $display("FAIL %s ZeroFlag: got %0b expected %0b", nm, zf, ez);
    end
  endtask

  task automatic add_vec(input string nm, input logic r, input logic m, input logic [3:0] s,
                         input logic [7:0] av, input logic [7:0] bv, input logic c,
                         input logic [7:0] ef, input logic ec);
    vec_t v;
    v.name = nm; v.rst = r; v.mode = m; v.sel = s; v.a = av; v.b = bv;
    v.cin = c; v.f = ef; v.co = ec;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] mf;
    logic       mc;

    add_vec("reset",        1, 0, 4'h9, 8'hF1, 8'h0F, 0, 8'h00, 0);
    add_vec("rst_release",  0, 0, 4'h9, 8'hF1, 8'h0F, 0, 8'h00, 1);
    add_vec("add_cin",      0, 0, 4'h9, 8'hF1, 8'h0F, 1, 8'h01, 1);
    add_vec("add",          0, 0, 4'h9, 8'h12, 8'h34, 0, 8'h46, 0);
    add_vec("sub",          0, 0, 4'h6, 8'h05, 8'h03, 1, 8'h02, 1);
    add_vec("sub_borrow",   0, 0, 4'h6, 8'h03, 8'h05, 1, 8'hFE, 0);
    add_vec("inc_wrap",     0, 0, 4'h0, 8'hFF, 8'h00, 1, 8'h00, 1);
    add_vec("dec",          0, 0, 4'hF, 8'hFF, 8'h00, 0, 8'hFE, 1);
    add_vec("dec_wrap",     0, 0, 4'hF, 8'h00, 8'h00, 0, 8'hFF, 0);
    add_vec("log_ones",     0, 1, 4'hC, 8'h5A, 8'h3C, 1, 8'hFF, 1);
    add_vec("log_zero",     0, 1, 4'h3, 8'h5A, 8'h3C, 1, 8'h00, 1);
    add_vec("log_and",      0, 1, 4'hB, 8'h04, 8'h0F, 1, 8'h04, 1);
    add_vec("log_nota",     0, 1, 4'h0, 8'hFF, 8'h0F, 1, 8'h00, 1);
    add_vec("log_xor_c0",   0, 1, 4'h6, 8'h5A, 8'h3C, 0, 8'h66, 0);
    add_vec("dbl",          0, 0, 4'hC, 8'h81, 8'h00, 0, 8'h02, 1);
    add_vec("rst_override", 1, 0, 4'h9, 8'hFF, 8'h01, 1, 8'h00, 0);
    add_vec("log_a_zero",   0, 1, 4'hF, 8'h00, 8'hFF, 0, 8'h00, 0);

    rst = 1'b1; mode = 1'b0; sel = 4'h0; a = 8'h00; b = 8'h00; cin = 1'b0;

    // Each vector is driven mid-cycle; outputs must hold the previous result
    // until the next rising edge, then show this vector's result.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; mode = vecs[i].mode; sel = vecs[i].sel;
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
      if (i > 0) begin
        #1;
        check_outs({vecs[i].name, "_hold"}, vecs[i-1].f, vecs[i-1].co);
      end
      @(posedge clk);
      #1;
      check_outs(vecs[i].name, vecs[i].f, vecs[i].co);
    end

    // Random operands across every Mode/Selector code, back to back
    for (int code = 0; code < 32; code++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        rst  = 1'b0;
        mode = code[4];
        sel  = code[3:0];
        a    = 8'($urandom_range(0, 255));
        b    = 8'($urandom_range(0, 255));
        cin  = 1'($urandom_range(0, 1));
        model(mode, sel, a, b, cin, mf, mc);
        @(posedge clk);
        #1;
        check_outs($sformatf("sweep_m%0d_s%0h", code[4], code[3:0]), mf, mc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
